// File: rtl/dac_i2s_transmitter.sv
// I2S master transmitter for a 24-bit stereo DAC: derives SCK/BCK/LRCK from
// cmn_clk and serialises one buffered sample pair per 64-BCK frame.
module dac_i2s_transmitter #(
    parameter int BCK_HALF = 49,
    parameter int SCK_BIT  = 3
) (
    input  logic        cmn_clk,
    input  logic        cmn_rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [23:0] s_left,
    input  logic [23:0] s_right,
    output logic        dac_sck,
    output logic        dac_bck,
    output logic        dac_lrck,
    output logic        dac_din,
    output logic        underrun,
    output logic        frame_start
);

    localparam int CW = (BCK_HALF > 2) ? $clog2(BCK_HALF) : 1;

    logic [3:0]    r_sck_cnt;
    logic [CW-1:0] r_bck_cnt;
    logic          r_bck;
    logic [5:0]    r_bit;
    logic          r_lrck;
    logic          r_din;
    logic          r_underrun;
    logic          r_frame_start;
    logic          r_tready;
    logic          r_full;
    logic [23:0]   r_sh_l;
    logic [23:0]   r_sh_r;
    logic [23:0]   r_buf_l;
    logic [23:0]   r_buf_r;

    logic          w_bck_tc;
    logic          w_fall;
    logic          w_load;
    logic          w_xfer;
    logic          w_full_nxt;
    logic [5:0]    w_bit_nxt;
    logic [4:0]    w_k;
    logic          w_in_word;
    logic          w_data_bit;

    assign w_bck_tc   = (r_bck_cnt == CW'(BCK_HALF - 1));
    assign w_fall     = w_bck_tc && r_bck;
    assign w_load     = w_fall && (r_bit == 6'd63);
    assign w_xfer     = s_tvalid && r_tready;
    assign w_bit_nxt  = r_bit + 6'd1;
    assign w_k        = w_bit_nxt[4:0];
    // Slot bit 0 is the I2S one-bit delay; bits 1..24 carry the word MSB first.
    assign w_in_word  = (w_k != 5'd0) && (w_k <= 5'd24);
    assign w_data_bit = w_bit_nxt[5] ? r_sh_r[23] : r_sh_l[23];
    // A transfer coinciding with a load from empty lands in the buffer.
    assign w_full_nxt = (r_full && !w_load) || w_xfer;

    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_sck_cnt <= 4'd0;
            r_bck_cnt <= '0;
            r_bck     <= 1'b0;
        end else begin
            r_sck_cnt <= r_sck_cnt + 4'd1;
            if (w_bck_tc) begin
                r_bck_cnt <= '0;
                r_bck     <= ~r_bck;
            end else begin
                r_bck_cnt <= r_bck_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_bit         <= 6'd63;
            r_lrck        <= 1'b0;
            r_din         <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_start <= 1'b0;
            r_sh_l        <= 24'd0;
            r_sh_r        <= 24'd0;
        end else begin
            r_underrun    <= w_load && !r_full;
            r_frame_start <= w_load;
            if (w_fall) begin
                r_bit  <= w_bit_nxt;
                r_lrck <= w_bit_nxt[5];
                r_din  <= w_in_word && w_data_bit;
                if (w_load) begin
                    r_sh_l <= r_full ? r_buf_l : 24'd0;
                    r_sh_r <= r_full ? r_buf_r : 24'd0;
                end else if (w_in_word) begin
                    if (w_bit_nxt[5]) begin
                        r_sh_r <= {r_sh_r[22:0], 1'b0};
                    end else begin
                        r_sh_l <= {r_sh_l[22:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_full   <= 1'b0;
            r_tready <= 1'b0;
            r_buf_l  <= 24'd0;
            r_buf_r  <= 24'd0;
        end else begin
            r_full   <= w_full_nxt;
            r_tready <= !w_full_nxt;
            if (w_xfer) begin
                r_buf_l <= s_left;
                r_buf_r <= s_right;
            end
        end
    end

    assign dac_sck     = r_sck_cnt[SCK_BIT];
    assign dac_bck     = r_bck;
    assign dac_lrck    = r_lrck;
    assign dac_din     = r_din;
    assign underrun    = r_underrun;
    assign frame_start = r_frame_start;
    assign s_tready    = r_tready;

endmodule

// File: tb/tb_dac_i2s_transmitter.sv
// Directed bench for dac_i2s_transmitter at default parameters.
`timescale 1ns/1ps
module tb_dac_i2s_transmitter;

    localparam int BCK_P   = 98;
    localparam int FRAME_P = 6272;
    localparam int SCK_P   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [23:0] s_left = 24'd0;
    logic [23:0] s_right = 24'd0;
    logic        dac_sck;
    logic        dac_bck;
    logic        dac_lrck;
    logic        dac_din;
    logic        underrun;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    dac_i2s_transmitter dut (
        .cmn_clk    (clk),
        .cmn_rst    (rst),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_left     (s_left),
        .s_right    (s_right),
        .dac_sck    (dac_sck),
        .dac_bck    (dac_bck),
        .dac_lrck   (dac_lrck),
        .dac_din    (dac_din),
        .underrun   (underrun),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] frame_word(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'd0, 1'b0, r, 7'd0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fs(output bit ok, output bit uf);
        int c;
        ok = 0;
        uf = 0;
        c = 0;
        while (!ok && c < 7000) begin
            @(negedge clk);
            c++;
            if (frame_start === 1'b1) begin
                ok = 1;
                uf = (underrun === 1'b1);
            end
        end
    endtask

    task automatic wait_rise(output bit ok);
        bit prv;
        int c;
        ok = 0;
        prv = dac_bck;
        c = 0;
        while (!ok && c < 300) begin
            @(negedge clk);
            c++;
            if (dac_bck && !prv) ok = 1;
            prv = dac_bck;
        end
    endtask

    task automatic capture(output logic [63:0] w, output bit uf, output int lr_err, output bit ok);
        bit r;
        w = '0;
        lr_err = 0;
        wait_fs(ok, uf);
        if (!ok) return;
        for (int i = 0; i < 64; i++) begin
            wait_rise(r);
            if (!r) begin
                ok = 0;
                return;
            end
            w[63-i] = dac_din;
            if (dac_lrck !== (i >= 32)) lr_err++;
        end
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r, output bit ok);
        int c;
        s_left = l;
        s_right = r;
        s_tvalid = 1'b1;
        ok = 0;
        c = 0;
        while (!ok && c < 20000) begin
            @(negedge clk);
            c++;
            if (s_tready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [63:0] exp, input bit exp_uf);
        logic [63:0] w;
        bit uf, ok;
        int lr;
        capture(w, uf, lr, ok);
        n_tests++;
        if (!ok || w !== exp) begin
            n_fail++;
            $display("FAIL %s_word: got %h ok=%0d want %h", name, w, ok, exp);
        end
        n_tests++;
        if (uf !== exp_uf) begin
            n_fail++;
            $display("FAIL %s_underrun: got %0d want %0d", name, uf, exp_uf);
        end
        n_tests++;
        if (lr != 0) begin
            n_fail++;
            $display("FAIL %s_lrck: got %0d bad slots want 0", name, lr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({dac_sck, dac_bck, dac_lrck, dac_din, underrun, frame_start, s_tready} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000000",
                {dac_sck, dac_bck, dac_lrck, dac_din, underrun, frame_start, s_tready});
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready_hold: got %b want 0", s_tready);
        end
        @(negedge clk);
        n_tests++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready_rise: got %b want 1", s_tready);
        end
    endtask

    task automatic test_idle_clocks();
        int r1[3], r2[3], f1[3];
        int ut[3];
        int n_ur;
        bit din_hi;
        logic [2:0] cur, prv;
        int exp_p[3], exp_h[3];
        string nm[3];
        exp_p = '{SCK_P, BCK_P, FRAME_P};
        exp_h = '{SCK_P / 2, BCK_P / 2, FRAME_P / 2};
        nm = '{"sck", "bck", "lrck"};
        for (int j = 0; j < 3; j++) begin
            r1[j] = -1;
            r2[j] = -1;
            f1[j] = -1;
            ut[j] = 0;
        end
        n_ur = 0;
        din_hi = 0;
        do_reset();
        prv = 3'b000;
        for (int c = 1; c <= 3 * FRAME_P; c++) begin
            @(negedge clk);
            cur = {dac_lrck, dac_bck, dac_sck};
            for (int j = 0; j < 3; j++) begin
                if (cur[j] && !prv[j]) begin
                    if (r1[j] < 0) r1[j] = c;
                    else if (r2[j] < 0) r2[j] = c;
                end
                if (!cur[j] && prv[j] && r1[j] >= 0 && f1[j] < 0) f1[j] = c;
            end
            prv = cur;
            if (underrun === 1'b1) begin
                if (n_ur < 3) ut[n_ur] = c;
                n_ur++;
            end
            if (dac_din !== 1'b0) din_hi = 1;
        end
        for (int j = 0; j < 3; j++) begin
            n_tests++;
            if (r1[j] < 0 || r2[j] - r1[j] != exp_p[j]) begin
                n_fail++;
                $display("FAIL %s_period: got %0d want %0d", nm[j], r2[j] - r1[j], exp_p[j]);
            end
            n_tests++;
            if (f1[j] < 0 || f1[j] - r1[j] != exp_h[j]) begin
                n_fail++;
                $display("FAIL %s_high: got %0d want %0d", nm[j], f1[j] - r1[j], exp_h[j]);
            end
        end
        n_tests++;
        if (n_ur != 3) begin
            n_fail++;
            $display("FAIL idle_underrun_count: got %0d want 3", n_ur);
        end
        n_tests++;
        if (ut[1] - ut[0] != FRAME_P || ut[2] - ut[1] != FRAME_P) begin
            n_fail++;
            $display("FAIL idle_underrun_spacing: got %0d,%0d want %0d", ut[1] - ut[0], ut[2] - ut[1], FRAME_P);
        end
        n_tests++;
        if (din_hi) begin
            n_fail++;
            $display("FAIL idle_din: got 1 want constant 0");
        end
    endtask

    task automatic test_single_sample();
        bit ok;
        do_reset();
        send(24'hA5A5A5, 24'h123456, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL v1_send: got timeout want transfer");
        end
        check_frame("v1", frame_word(24'hA5A5A5, 24'h123456), 1'b0);
    endtask

    task automatic test_back_to_back();
        bit stop;
        int nx;
        stop = 0;
        nx = 0;
        do_reset();
        fork
            begin
                s_left = 24'hC00000;
                s_right = 24'h0F0F00;
                s_tvalid = 1'b1;
                while (!stop) begin
                    @(negedge clk);
                    if (s_tready && !stop) begin
                        @(posedge clk);
                        #1;
                        nx++;
                        s_left = 24'hC00000 + 24'(nx);
                        s_right = 24'h0F0F00 + 24'(nx);
                    end
                end
                s_tvalid = 1'b0;
            end
            begin
                check_frame("b2b_f0", frame_word(24'hC00000, 24'h0F0F00), 1'b0);
                check_frame("b2b_f1", frame_word(24'hC00001, 24'h0F0F01), 1'b0);
                check_frame("b2b_f2", frame_word(24'hC00002, 24'h0F0F02), 1'b0);
                stop = 1;
            end
        join
        n_tests++;
        if (nx != 4) begin
            n_fail++;
            $display("FAIL b2b_transfers: got %0d want 4", nx);
        end
    endtask

    task automatic test_coincide();
        bit ok, uf;
        do_reset();
        wait_fs(ok, uf);
        n_tests++;
        if (!ok || !uf) begin
            n_fail++;
            $display("FAIL v5_first_load: got ok=%0d uf=%0d want 1 1", ok, uf);
        end
        repeat (FRAME_P - 1) @(posedge clk);
        #1;
        s_left = 24'h3C3C3C;
        s_right = 24'hFEDCBA;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        n_tests++;
        if (s_tready !== 1'b0 || frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL v5_accept: got tready=%b fs=%b want 0 1", s_tready, frame_start);
        end
        check_frame("v5_zero", 64'd0, 1'b1);
        check_frame("v5_data", frame_word(24'h3C3C3C, 24'hFEDCBA), 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok, uf, prv;
        int falls, c;
        do_reset();
        send(24'h111111, 24'h222222, ok);
        wait_fs(ok, uf);
        send(24'h333333, 24'h444444, ok);
        falls = 0;
        c = 0;
        prv = dac_bck;
        while (falls < 40 && c < 5000) begin
            @(negedge clk);
            c++;
            if (!dac_bck && prv) falls++;
            prv = dac_bck;
        end
        n_tests++;
        if (falls != 40 || dac_lrck !== 1'b1) begin
            n_fail++;
            $display("FAIL v6_reach_bit40: got falls=%0d lrck=%b want 40 1", falls, dac_lrck);
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({dac_sck, dac_bck, dac_lrck, dac_din, underrun, frame_start, s_tready} !== 7'd0) begin
            n_fail++;
            $display("FAIL v6_async_clear: got %b want 0000000",
                {dac_sck, dac_bck, dac_lrck, dac_din, underrun, frame_start, s_tready});
        end
        @(negedge clk);
        rst = 1'b0;
        check_frame("v6_after", 64'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_idle_clocks();
        test_single_sample();
        test_back_to_back();
        test_coincide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_i2s_transmitter.md
DAC_I2S_TRANSMITTER -- requirements
Module: dac_i2s_transmitter

Interface
- REQ-001 SHALL have parameter BCK_HALF, default 49, meaning cmn_clk cycles per BCK half-period; legal range >= 2.
- REQ-002 SHALL have parameter SCK_BIT, default 3, meaning the free-running divider bit driven on dac_sck (100 MHz / 16 = 6.25 MHz).
- REQ-003 cmn_clk  in  1  100 MHz system clock; the only clock in the block.
- REQ-004 cmn_rst  in  1  common reset, asynchronous, active-high.
- REQ-005 s_tvalid  in  1  stereo sample pair valid.
- REQ-006 s_tready  out  1  block can accept a sample pair (registered).
- REQ-007 s_left  in  24  left-channel sample, two's complement.
- REQ-008 s_right  in  24  right-channel sample, two's complement.
- REQ-009 dac_sck  out  1  DAC system clock.
- REQ-010 dac_bck  out  1  I2S bit clock (master).
- REQ-011 dac_lrck  out  1  I2S word select; 0 = left slot, 1 = right slot.
- REQ-012 dac_din  out  1  I2S serial data.
- REQ-013 underrun  out  1  one-cycle pulse; frame started with no sample buffered.
- REQ-014 frame_start  out  1  one-cycle pulse at every frame load.

Function
- REQ-015 A 4-bit free-running counter SHALL drive dac_sck from bit SCK_BIT.
- REQ-016 A BCK divider counter SHALL count 0..BCK_HALF-1 and toggle dac_bck on terminal count; BCK period = 2*BCK_HALF cmn_clk cycles (98 at default).
- REQ-017 All of dac_lrck, dac_din, bit counter and shift registers SHALL update only in the cmn_clk cycle where dac_bck toggles 1->0 (the "fall event"); the DAC samples on BCK rising.
- REQ-018 A 6-bit bit counter SHALL increment on each fall event and wrap 63->0; frame = 64 BCK = 128*BCK_HALF cmn_clk (6272 at default, ~15.9 kHz).
- REQ-019 dac_lrck SHALL be 0 while bit counter is 0..31 and 1 while it is 32..63.
- REQ-020 dac_din SHALL follow the I2S one-bit delay: slot bit index k = 0 outputs 0; k = 1..24 output sample bit 24-k (MSB first); k = 25..31 output 0.
- REQ-021 A one-entry holding buffer SHALL store {s_left, s_right}; a transfer occurs when s_tvalid && s_tready on a cmn_clk edge.
- REQ-022 s_tready SHALL be 0 in the cycle after a transfer and stay 0 while the buffer is full.
- REQ-023 Frame load SHALL occur on the fall event where the bit counter wraps 63->0.
- REQ-024 At frame load with buffer full, the left/right shift registers SHALL load from the buffer, the buffer SHALL empty, and s_tready SHALL be 1 the next cycle.
- REQ-025 At frame load with buffer empty, both shift registers SHALL load zero and underrun SHALL pulse for exactly 1 cycle.
- REQ-026 If a transfer and a frame load coincide with the buffer empty, the sample SHALL be buffered for the next frame; the current frame transmits zero and underrun pulses.
- REQ-027 frame_start SHALL pulse for 1 cycle on every frame load, aligned with the dac_lrck 1->0 transition.
- REQ-028 A sample held in the buffer SHALL never be overwritten or dropped except by reset.

Reset
- REQ-029 On cmn_rst assertion, the following SHALL take effect immediately and asynchronously: dac_sck, dac_bck, dac_lrck, dac_din, underrun, frame_start, s_tready = 0; buffer empty; shift registers 0; dividers 0; bit counter = 63.
- REQ-030 s_tready SHALL rise in the first cmn_clk cycle after reset deassertion.
- REQ-031 The first fall event after reset SHALL be a frame load.
- REQ-032 Reset mid-frame SHALL abandon the frame and the buffered sample without emitting a partial word afterwards.

Verification
- V1: reset, send L=24'hA5A5A5, R=24'h123456 -> at BCK rising edges after LRCK falls: 0, A5A5A5 MSB-first, 7 zeros; after LRCK rises: 0, 123456, 7 zeros.
- V2: no input for 3 frames -> dac_din constantly 0, underrun pulses 3 times, 6272 cycles apart.
- V3: s_tvalid held high with an incrementing sample -> one transfer per frame, s_tready low between loads, consecutive frames carry consecutive samples, no underrun.
- V4: default parameters -> dac_bck period 98 cycles, dac_lrck period 6272 cycles, dac_sck period 16 cycles, 50% duty cycle.
- V5: s_tvalid first asserted in the exact frame-load cycle with buffer empty -> underrun pulse, that frame is zero, the sample appears in the next frame.
- V6: cmn_rst asserted at bit counter 40 -> all outputs 0 within the same cycle; after release the first frame is a zero frame with underrun unless fed.
